// File: rtl/slc3_mem_pkg.sv
// rtl/slc3_mem_pkg.sv - shared types and helpers for the SLC-3 SRAM responder
package slc3_mem_pkg;

    typedef enum logic [2:0] {INIT, IDLE, READ_WAIT, READ_HOLD, WRITE} mem_state_t;

    typedef logic [15:0] word_t;

    localparam word_t MEM_ZERO = 16'h0000;

    // Any address bit above the implemented array puts the access out of range.
    function automatic logic addr_in_range(input word_t a, input int unsigned aw);
        return (a >> aw) == 16'd0;
    endfunction

endpackage

// File: rtl/sram_array.sv
// rtl/sram_array.sv - DEPTH x 16 word array, synchronous write, combinational read
module sram_array
    import slc3_mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  word_t             wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output word_t             rd_data
);

    word_t mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/slc3_sram_responder.sv
// rtl/slc3_sram_responder.sv - SLC-3 memory-bus responder with zero-fill and load port
module slc3_sram_responder
    import slc3_mem_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int READ_LAT = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        OE,
    input  logic        WE,
    input  logic [15:0] ADDR,
    input  logic [15:0] Data_to_SRAM,
    output logic [15:0] Data_from_SRAM,
    output logic        Init_busy,
    input  logic        Ld_valid,
    output logic        Ld_ready,
    input  logic [15:0] Ld_addr,
    input  logic [15:0] Ld_data
);

    localparam logic [2:0]        LAT_LAST = 3'(READ_LAT);
    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    mem_state_t        state;
    logic [ADDR_W-1:0] init_cnt;
    logic [2:0]        lat_cnt;
    word_t             rd_addr_q;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    word_t             wr_data;
    word_t             rd_data;

    sram_array #(.ADDR_W(ADDR_W)) u_array (
        .clk     (Clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr_q[ADDR_W-1:0]),
        .rd_data (rd_data)
    );

    // The loader only gets the bus when the CPU is completely idle.
    assign Ld_ready = !Reset && (state == IDLE) && OE && WE;

    // Write-port source select; a CPU write commits on the cycle it leaves a non-WRITE state.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = ADDR[ADDR_W-1:0];
        wr_data = Data_to_SRAM;
        if (!Reset) begin
            case (state)
                INIT: begin
                    wr_en   = 1'b1;
                    wr_addr = init_cnt;
                    wr_data = MEM_ZERO;
                end
                IDLE, READ_WAIT, READ_HOLD: begin
                    if (!WE) begin
                        wr_en = addr_in_range(ADDR, ADDR_W);
                    end else if (state == IDLE && OE && Ld_valid) begin
                        wr_en   = addr_in_range(Ld_addr, ADDR_W);
                        wr_addr = Ld_addr[ADDR_W-1:0];
                        wr_data = Ld_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state          <= INIT;
            init_cnt       <= '0;
            Data_from_SRAM <= MEM_ZERO;
            Init_busy      <= 1'b1;
            lat_cnt        <= '0;
        end else begin
            case (state)
                INIT: begin
                    init_cnt <= init_cnt + ADDR_W'(1);
                    if (init_cnt == CNT_LAST) begin
                        state     <= IDLE;
                        Init_busy <= 1'b0;
                    end
                end
                IDLE: begin
                    if (!WE) begin
                        state <= WRITE;
                    end else if (!OE) begin
                        rd_addr_q <= ADDR;
                        lat_cnt   <= 3'd1;
                        state     <= READ_WAIT;
                    end
                end
                READ_WAIT: begin
                    if (!WE) begin
                        state <= WRITE;
                    end else if (OE) begin
                        state <= IDLE;
                    end else if (lat_cnt == LAT_LAST) begin
                        Data_from_SRAM <= addr_in_range(rd_addr_q, ADDR_W) ? rd_data : MEM_ZERO;
                        state          <= READ_HOLD;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                READ_HOLD: begin
                    if (!WE) begin
                        state <= WRITE;
                    end else if (OE) begin
                        state <= IDLE;
                    end else if (ADDR != rd_addr_q) begin
                        rd_addr_q <= ADDR;
                        lat_cnt   <= 3'd1;
                        state     <= READ_WAIT;
                    end
                end
                WRITE: begin
                    if (WE) begin
                        state <= IDLE;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_slc3_sram_responder.sv
// tb/tb_slc3_sram_responder.sv - self-checking bench for slc3_sram_responder
module tb_slc3_sram_responder;

    localparam int ADDR_W   = 10;
    localparam int DEPTH    = 1 << ADDR_W;
    localparam int READ_LAT = 2;

    logic        Clk;
    logic        Reset;
    logic        OE;
    logic        WE;
    logic [15:0] ADDR;
    logic [15:0] Data_to_SRAM;
    logic [15:0] Data_from_SRAM;
    logic        Init_busy;
    logic        Ld_valid;
    logic        Ld_ready;
    logic [15:0] Ld_addr;
    logic [15:0] Ld_data;

    slc3_sram_responder #(.ADDR_W(ADDR_W), .READ_LAT(READ_LAT)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .OE             (OE),
        .WE             (WE),
        .ADDR           (ADDR),
        .Data_to_SRAM   (Data_to_SRAM),
        .Data_from_SRAM (Data_from_SRAM),
        .Init_busy      (Init_busy),
        .Ld_valid       (Ld_valid),
        .Ld_ready       (Ld_ready),
        .Ld_addr        (Ld_addr),
        .Ld_data        (Ld_data)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: memory contents, read age, write-held flag.
    logic [15:0] mm [DEPTH];
    bit          started = 0;
    int          init_left = 0;
    logic [15:0] e_dout = 16'h0;
    logic        e_busy = 1'b1;
    bit          active = 0;
    bit          writing = 0;
    logic [15:0] raddr = 16'h0;
    int          age = 0;

    function automatic bit inr(input logic [15:0] a);
        return a < 16'(DEPTH);
    endfunction

    always @(posedge Clk) begin
        if (Reset) begin
            started   = 1;
            init_left = DEPTH;
            e_dout    = 16'h0;
            e_busy    = 1'b1;
            active    = 0;
            writing   = 0;
            for (int i = 0; i < DEPTH; i++) mm[i] = 16'h0;
        end else if (started) begin
            if (init_left > 0) begin
                init_left--;
                if (init_left == 0) e_busy = 1'b0;
            end else if (!WE) begin
                if (!writing && inr(ADDR)) mm[ADDR[ADDR_W-1:0]] = Data_to_SRAM;
                writing = 1;
                active  = 0;
            end else if (writing) begin
                writing = 0;
            end else if (!OE) begin
                if (!active) begin
                    active = 1;
                    raddr  = ADDR;
                    age    = 0;
                end else if (age == READ_LAT && ADDR != raddr) begin
                    raddr = ADDR;
                    age   = 0;
                end else if (age < READ_LAT) begin
                    age++;
                    if (age == READ_LAT) e_dout = inr(raddr) ? mm[raddr[ADDR_W-1:0]] : 16'h0;
                end
            end else begin
                if (!active && Ld_valid && inr(Ld_addr)) mm[Ld_addr[ADDR_W-1:0]] = Ld_data;
                active = 0;
            end
        end
    end

    always @(negedge Clk) begin
        if (started && !Reset) begin
            chk("cyc_dout", Data_from_SRAM, e_dout);
            chk("cyc_busy", 16'(Init_busy), 16'(e_busy));
            chk("cyc_ready", 16'(Ld_ready),
                16'(!e_busy && !writing && !active && OE && WE));
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_read(input logic [15:0] a, output logic [15:0] d);
        ADDR = a;
        OE   = 1'b0;
        tick();
        repeat (READ_LAT) tick();
        d  = Data_from_SRAM;
        OE = 1'b1;
        tick();
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d);
        ADDR         = a;
        Data_to_SRAM = d;
        WE           = 1'b0;
        tick();
        WE = 1'b1;
        tick();
    endtask

    task automatic do_load(input logic [15:0] a, input logic [15:0] d);
        int n = 0;
        Ld_addr  = a;
        Ld_data  = d;
        Ld_valid = 1'b1;
        #1;
        while (!Ld_ready && n < 20) begin
            tick();
            n++;
        end
        chk("ld_handshake", 16'(Ld_ready), 16'h1);
        tick();
        Ld_valid = 1'b0;
    endtask

    task automatic wait_init(input string name);
        int n = 0;
        while (Init_busy && n < DEPTH + 50) begin
            tick();
            n++;
        end
        chk(name, 16'(Init_busy), 16'h0);
    endtask

    logic [15:0] d;
    int          n;

    initial begin
        Reset = 1'b1; OE = 1'b1; WE = 1'b1; ADDR = 16'h0; Data_to_SRAM = 16'h0;
        Ld_valid = 1'b0; Ld_addr = 16'h0; Ld_data = 16'h0;

        // T1: zero-fill length and contents
        tick();
        Reset = 1'b0;
        chk("t1_reset_dout", Data_from_SRAM, 16'h0);
        chk("t1_reset_ready", 16'(Ld_ready), 16'h0);
        n = 0;
        while (Init_busy && n < 2000) begin
            n++;
            tick();
        end
        chk("t1_busy_cycles", 16'(n), 16'd1024);
        do_read(16'h0005, d);
        chk("t1_read5", d, 16'h0000);

        // T2: load port then exact read latency
        do_load(16'h0010, 16'h1234);
        ADDR = 16'h0010;
        OE   = 1'b0;
        tick();
        tick();
        chk("t2_before_lat", Data_from_SRAM, 16'h0000);
        tick();
        chk("t2_at_lat", Data_from_SRAM, 16'h1234);
        tick();
        chk("t2_hold", Data_from_SRAM, 16'h1234);
        OE = 1'b1;
        tick();

        // T3: long WE assertion commits only the first-cycle data
        ADDR = 16'h0020; Data_to_SRAM = 16'hBEEF; WE = 1'b0;
        tick();
        Data_to_SRAM = 16'h0000;
        repeat (3) tick();
        WE = 1'b1;
        tick();
        do_read(16'h0020, d);
        chk("t3_single_commit", d, 16'hBEEF);

        // T4: write priority over read, loader locked out during CPU traffic
        ADDR = 16'h0030; Data_to_SRAM = 16'hA5A5; OE = 1'b0; WE = 1'b0;
        Ld_valid = 1'b1; Ld_addr = 16'h0040; Ld_data = 16'hFFFF;
        #1;
        chk("t4_ready_low0", 16'(Ld_ready), 16'h0);
        tick();
        chk("t4_ready_low1", 16'(Ld_ready), 16'h0);
        Ld_valid = 1'b0; WE = 1'b1; OE = 1'b1;
        tick();
        do_read(16'h0030, d);
        chk("t4_write_won", d, 16'hA5A5);
        do_read(16'h0040, d);
        chk("t4_no_load", d, 16'h0000);

        // T5: out-of-range accesses
        do_read(16'h0010, d);
        do_read(16'h8000, d);
        chk("t5_oor_read", d, 16'h0000);
        do_write(16'h8000, 16'h7777);
        do_read(16'h0000, d);
        chk("t5_alias_untouched", d, 16'h0000);

        // T6: reset during READ_WAIT, during WRITE, and with a write pending
        ADDR = 16'h0010; OE = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0; OE = 1'b1;
        chk("t6_rd_dout", Data_from_SRAM, 16'h0000);
        chk("t6_rd_busy", 16'(Init_busy), 16'h1);
        wait_init("t6_rd_init_done");
        do_read(16'h0010, d);
        chk("t6_rd_cleared", d, 16'h0000);

        ADDR = 16'h0050; Data_to_SRAM = 16'h9999; WE = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0; WE = 1'b1;
        chk("t6_wr_busy", 16'(Init_busy), 16'h1);
        wait_init("t6_wr_init_done");

        ADDR = 16'h0060; Data_to_SRAM = 16'h4321; WE = 1'b0; Reset = 1'b1;
        tick();
        Reset = 1'b0; WE = 1'b1;
        chk("t6_pend_dout", Data_from_SRAM, 16'h0000);
        chk("t6_pend_busy", 16'(Init_busy), 16'h1);
        wait_init("t6_pend_init_done");
        do_read(16'h0060, d);
        chk("t6_pend_not_committed", d, 16'h0000);

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 4000; i++) begin
            if (!WE) WE = ($urandom_range(0, 1) == 0);
            else     WE = ($urandom_range(0, 9) != 0);
            OE = ($urandom_range(0, 9) < 4);
            if ($urandom_range(0, 3) == 0) begin
                ADDR = 16'($urandom_range(0, 15));
                if ($urandom_range(0, 7) == 0) ADDR = ADDR | 16'h8000;
            end
            Data_to_SRAM = 16'($urandom);
            Ld_valid     = $urandom_range(0, 1) == 1;
            Ld_addr      = 16'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) Ld_addr = Ld_addr | 16'h0400;
            Ld_data = 16'($urandom);
            tick();
        end
        OE = 1'b1; WE = 1'b1; Ld_valid = 1'b0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
